store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 138 +++++++++++++
 tb/tb_store_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and the data-memory write port.
// Optional load forwarding of full-word stores is enabled with macro STBUF_FWD_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_be,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        ld_fwd_valid,
  output logic [31:0] ld_fwd_data,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_pc,
  output logic        empty,
  output logic [4:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [4:0]      count_q, count_d;

  logic push;
  logic pop;

  assign in_ready  = (count_q < 5'(DEPTH));
  assign empty     = (count_q == 5'd0);
  assign count     = count_q;
  assign mem_we    = !empty && !mem_busy;
  assign mem_addr  = {ent_q[head_q].addr, 2'b00};
  assign mem_wdata = ent_q[head_q].wdata;
  assign mem_be    = ent_q[head_q].be;
  assign mem_pc    = ent_q[head_q].pc;

  assign push = in_valid && in_ready;
  assign pop  = mem_we;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + 5'(push) - 5'(pop);
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      ent_d[tail_q]   = '{addr: in_addr[31:2], wdata: in_wdata, be: in_be, pc: in_pc};
      tail_d          = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  logic          match_any;
  logic [3:0]    young_be;
  logic [31:0]   young_data;
  logic [PW-1:0] idx;
  logic          fwd;

  // Scan oldest to youngest from head so the last hit is the youngest match.
  always_comb begin
    match_any  = 1'b0;
    young_be   = '0;
    young_data = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (ent_q[idx].addr == ld_addr[31:2])) begin
        match_any  = 1'b1;
        young_be   = ent_q[idx].be;
        young_data = ent_q[idx].wdata;
      end
    end
  end

`ifdef STBUF_FWD_EN
  assign fwd          = ld_valid && match_any && (young_be == 4'hF);
  assign ld_fwd_data  = fwd ? young_data : '0;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{young_be, young_data};
  assign fwd          = 1'b0;
  assign ld_fwd_data  = '0;
`endif

  assign ld_fwd_valid = fwd;
  assign ld_stall     = ld_valid && match_any && !fwd;

  logic unused_bits;
  assign unused_bits = ^{in_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [3:0]  in_be;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        mem_busy;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_pc;
  logic        empty;
  logic [4:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_be        (in_be),
    .in_pc        (in_pc),
    .in_ready     (in_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_stall     (ld_stall),
    .ld_fwd_valid (ld_fwd_valid),
    .ld_fwd_data  (ld_fwd_data),
    .mem_busy     (mem_busy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_pc       (mem_pc),
    .empty        (empty),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } st_t;

  st_t model_q[$];
  int unsigned writes_seen = 0;

  // One clock: drive inputs after the falling edge, compare against the model,
  // then advance the model across the rising edge.
  task automatic cycle(input logic rst, input logic iv, input logic [31:0] ia,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] pc,
                       input logic lv, input logic [31:0] la, input logic busy);
    logic        e_ready, e_we, e_match, e_fwd, e_stall;
    logic [3:0]  y_be;
    logic [31:0] y_data, e_fdata;
    logic [29:0] la_w, qa_w;
    st_t         ns;
    reset = rst; in_valid = iv; in_addr = ia; in_wdata = wd; in_be = be; in_pc = pc;
    ld_valid = lv; ld_addr = la; mem_busy = busy;
    #1;
    e_ready = (model_q.size() < DEPTH);
    e_we    = (model_q.size() != 0) && !busy;
    check("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    check("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
    check("count", {27'd0, count}, model_q.size());
    check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    if (e_we) begin
      check("mem_addr", mem_addr, {model_q[0].addr[31:2], 2'b00});
      check("mem_wdata", mem_wdata, model_q[0].wdata);
      check("mem_be", {28'd0, mem_be}, {28'd0, model_q[0].be});
      check("mem_pc", mem_pc, model_q[0].pc);
    end
    e_match = 1'b0; y_be = '0; y_data = '0;
    la_w = la[31:2];
    foreach (model_q[i]) begin
      qa_w = model_q[i].addr[31:2];
      if (qa_w == la_w) begin
        e_match = 1'b1; y_be = model_q[i].be; y_data = model_q[i].wdata;
      end
    end
`ifdef STBUF_FWD_EN
    e_fwd = lv && e_match && (y_be == 4'hF);
`else
    e_fwd = 1'b0;
`endif
    e_fdata = e_fwd ? y_data : 32'd0;
    e_stall = lv && e_match && !e_fwd;
    check("ld_stall", {31'd0, ld_stall}, {31'd0, e_stall});
    check("ld_fwd_valid", {31'd0, ld_fwd_valid}, {31'd0, e_fwd});
    check("ld_fwd_data", ld_fwd_data, e_fdata);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (e_we) begin
        void'(model_q.pop_front());
        writes_seen++;
      end
      if (iv && e_ready) begin
        ns.addr = ia; ns.wdata = wd; ns.be = be; ns.pc = pc;
        model_q.push_back(ns);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic busy, input logic lv, input logic [31:0] la);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, lv, la, busy);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic busy);
    cycle(1'b0, 1'b1, a, d, be, a + 32'h1000, 1'b0, 32'd0, busy);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_be = '0; in_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_q.delete();

    // Single word store drains the next cycle.
    do_reset();
    store(32'h10, 32'h11223344, 4'hF, 1'b0);
    check("r035_mem_addr", mem_addr, 32'h10);
    check("r035_mem_wdata", mem_wdata, 32'h11223344);
    idle(1'b0, 1'b0, 32'd0);
    check("r035_empty", {31'd0, empty}, 32'd1);

    // Fill while busy, drop the fifth, then drain in order.
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA000 + 32'(i), 4'hF, 1'b1);
    check("r036_count", {27'd0, count}, 32'd4);
    check("r036_ready", {31'd0, in_ready}, 32'd0);
    store(32'h100, 32'hDEAD, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("r036_order", mem_addr, 32'(i * 4));
      idle(1'b0, 1'b0, 32'd0);
    end
    check("r036_drained", {31'd0, empty}, 32'd1);

    // Full buffer: store offered during a drain is refused, then accepted.
    for (int i = 0; i < 4; i++) store(32'h200 + 32'(i * 4), 32'(i), 4'hF, 1'b1);
    store(32'h300, 32'h3333, 4'hF, 1'b0);
    check("r037_count", {27'd0, count}, 32'd3);
    store(32'h300, 32'h3333, 4'hF, 1'b1);
    check("r037_count2", {27'd0, count}, 32'd4);
    repeat (5) idle(1'b0, 1'b0, 32'd0);

    // Sub-word store blocks a same-word load until drained.
    store(32'h21, 32'h0000_5500, 4'b0010, 1'b1);
    idle(1'b1, 1'b1, 32'h20);
    idle(1'b1, 1'b1, 32'h20);
    idle(1'b0, 1'b1, 32'h20);
    idle(1'b0, 1'b1, 32'h20);

    // Two word stores to the same address: youngest forwards (or stalls).
    store(32'h40, 32'hAAAAAAAA, 4'hF, 1'b1);
    store(32'h40, 32'hBBBBBBBB, 4'hF, 1'b1);
    idle(1'b1, 1'b1, 32'h40);
    idle(1'b1, 1'b1, 32'h43);
    repeat (3) idle(1'b0, 1'b1, 32'h40);

    // Reset discards pending stores.
    for (int i = 0; i < 3; i++) store(32'h500 + 32'(i * 4), 32'h5000 + 32'(i), 4'hF, 1'b1);
    do_reset();
    check("r040_count", {27'd0, count}, 32'd0);
    check("r040_we", {31'd0, mem_we}, 32'd0);
    repeat (3) idle(1'b0, 1'b0, 32'd0);

    // Random traffic over a small address window to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      logic        rr, iv, lv, bz;
      logic [3:0]  be;
      rr = ($urandom_range(0, 79) == 0);
      iv = ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 1) != 0);
      bz = ($urandom_range(0, 2) == 0);
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      cycle(rr, iv, 32'($urandom_range(0, 31)), $urandom, be, $urandom,
            lv, 32'($urandom_range(0, 31)), bz);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
